// File: rtl/mgu_edge_scatter.sv
// Message generation unit: walks an activated vertex's edge list in HBM
// beats and emits one {dest addr, candidate value} update per edge.
module mgu_edge_scatter #(
    parameter int unsigned          VPropWidth   = 32,
    parameter int unsigned          EIndexWidth  = 32,
    parameter int unsigned          EDegreeWidth = 32,
    parameter int unsigned          AddrWidth    = 33,
    parameter int unsigned          DataWidth    = 256,
    parameter int unsigned          UpdateWidth  = AddrWidth + VPropWidth,
    parameter int unsigned          EdgeWidth    = 64,
    parameter logic [AddrWidth-1:0] EdgeBase     = 33'h1_0000_0000,
    parameter int unsigned          VertexShift  = 5
) (
    input  logic                                               clk,
    input  logic                                               resetn,
    input  logic [VPropWidth+EIndexWidth+EDegreeWidth:0]        mgu_data,
    input  logic                                               mgu_ready,
    output logic                                               mgu_resp,
    input  logic [1:0]                                         control,
    output logic [AddrWidth-1:0]                               read_addr,
    output logic                                               start_rd,
    input  logic                                               end_rd,
    input  logic [DataWidth-1:0]                               read_data,
    output logic [UpdateWidth-1:0]                             update,
    output logic                                               update_ready,
    input  logic                                               update_resp,
    output logic                                               busy
);

    localparam int unsigned Lanes     = DataWidth / EdgeWidth;
    localparam int unsigned LaneBits  = $clog2(Lanes);
    localparam int unsigned BeatShift = $clog2(DataWidth / 8);
    localparam int unsigned HalfEdge  = EdgeWidth / 2;
    localparam int unsigned DataTop   = VPropWidth + EIndexWidth + EDegreeWidth;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        READ,
        READ_WAIT,
        EMIT,
        EMIT_WAIT
    } state_e;

    state_e                                state_q, state_d;
    logic [VPropWidth-1:0]                 prop_q, prop_d;
    logic [EIndexWidth-1:0]                idx_q, idx_d;
    logic [EDegreeWidth-1:0]               rem_q, rem_d;
    logic [1:0]                            ctl_q, ctl_d;
    logic [Lanes-1:0][EdgeWidth-1:0]       beat_q, beat_d;

    logic                                  unused_msb;
    logic [EdgeWidth-1:0]                  edge_sel;
    logic [HalfEdge-1:0]                   dest_idx;
    logic [VPropWidth-1:0]                 addend;
    logic [VPropWidth:0]                   sum;
    logic [VPropWidth-1:0]                 value;
    logic [AddrWidth-1:0]                  dest_addr;
    logic [AddrWidth-1:0]                  beat_off;

    assign unused_msb = mgu_data[DataTop];

    // lane currently being emitted is always the low bits of the edge index
    assign edge_sel  = beat_q[idx_q[LaneBits-1:0]];
    assign dest_idx  = edge_sel[HalfEdge-1:0];
    assign dest_addr = AddrWidth'({dest_idx, {VertexShift{1'b0}}});
    assign beat_off  = AddrWidth'({idx_q[EIndexWidth-1:LaneBits], {BeatShift{1'b0}}});

    always_comb begin
        addend = '0;
        unique case (1'b1)
            (ctl_q == 2'b10): addend = VPropWidth'(edge_sel[EdgeWidth-1:HalfEdge]);
            (ctl_q == 2'b01): addend = VPropWidth'(1);
            default:          addend = '0;
        endcase
    end

    assign sum   = {1'b0, prop_q} + {1'b0, addend};
    assign value = sum[VPropWidth] ? {VPropWidth{1'b1}} : sum[VPropWidth-1:0];

    assign mgu_resp     = (state_q == ACCEPT);
    assign start_rd     = (state_q == READ);
    assign update_ready = (state_q == EMIT);
    assign busy         = (state_q != IDLE);
    assign read_addr    = start_rd ? (EdgeBase + beat_off) : '0;
    assign update       = update_ready ? {dest_addr, value} : '0;

    always_comb begin
        state_d = state_q;
        prop_d  = prop_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        ctl_d   = ctl_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (mgu_ready) begin
                    rem_d   = mgu_data[EDegreeWidth-1:0];
                    idx_d   = mgu_data[EIndexWidth+EDegreeWidth-1:EDegreeWidth];
                    prop_d  = mgu_data[DataTop-1 -: VPropWidth];
                    ctl_d   = control;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                state_d = (rem_q == '0) ? IDLE : READ;
            end
            READ: begin
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                if (end_rd) begin
                    beat_d  = read_data;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (update_resp) begin
                    rem_d   = rem_q - 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = EMIT_WAIT;
                end
            end
            EMIT_WAIT: begin
                // consumer holds resp for several cycles; wait for release
                if (!update_resp) begin
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end else if (idx_q[LaneBits-1:0] == '0) begin
                        state_d = READ;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            prop_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            ctl_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            prop_q  <= prop_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            ctl_q   <= ctl_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_mgu_edge_scatter.sv
// Bench for mgu_edge_scatter: HBM and update-consumer responders plus an
// edge-list reference model producing the expected reads and updates.
module tb_mgu_edge_scatter;

    localparam logic [32:0] EdgeBase = 33'h1_0000_0000;
    localparam longint unsigned AMod = 64'd1 << 33;

    logic         clk = 1'b0;
    logic         resetn;
    logic [96:0]  mgu_data;
    logic         mgu_ready;
    logic         mgu_resp;
    logic [1:0]   control;
    logic [32:0]  read_addr;
    logic         start_rd;
    logic         end_rd;
    logic [255:0] read_data;
    logic [64:0]  update;
    logic         update_ready;
    logic         update_resp;
    logic         busy;

    mgu_edge_scatter dut (
        .clk          (clk),
        .resetn       (resetn),
        .mgu_data     (mgu_data),
        .mgu_ready    (mgu_ready),
        .mgu_resp     (mgu_resp),
        .control      (control),
        .read_addr    (read_addr),
        .start_rd     (start_rd),
        .end_rd       (end_rd),
        .read_data    (read_data),
        .update       (update),
        .update_ready (update_ready),
        .update_resp  (update_resp),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] edge_mem [int unsigned];
    logic [64:0] exp_up [$];
    logic [32:0] exp_rd [$];
    int          nrd_exp;
    int          n_upd, n_rd, n_resp;
    logic [64:0] last_upd;
    logic [32:0] first_rd, last_rd;
    int          hold_mode = -1;
    int          cstate = 0;
    int          cwait;
    logic [64:0] cap;
    bit          stable;
    bit          hbm_pend = 0;
    int          hbm_wait;
    logic [32:0] hbm_addr;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] edge_at(input int unsigned j);
        if (edge_mem.exists(j)) return edge_mem[j];
        return {j * 32'h9E37_79B1 ^ 32'hA5A5_0F0F, j * 32'h0001_0193 + 32'd17};
    endfunction

    function automatic logic [255:0] beat_at(input logic [32:0] a);
        logic [32:0]  off;
        int unsigned  b;
        logic [255:0] d;
        off = a - EdgeBase;
        b   = 32'(off[32:5]);
        for (int l = 0; l < 4; l++) d[l*64 +: 64] = edge_at(b * 4 + l);
        return d;
    endfunction

    function automatic logic [31:0] exp_val(input logic [31:0] p, input logic [31:0] w,
                                            input logic [1:0] c);
        longint unsigned s;
        s = 64'(p);
        if (c == 2'b10) s += 64'(w);
        else if (c == 2'b01) s += 1;
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // expected HBM reads and updates for one record, edge by edge
    task automatic model(input logic [31:0] prop, input logic [31:0] idx,
                         input logic [31:0] deg, input logic [1:0] ctl);
        int unsigned     j, b, lastb;
        logic [63:0]     ed;
        longint unsigned ra, da;
        nrd_exp = 0;
        lastb   = 0;
        for (int unsigned e = 0; e < deg; e++) begin
            j = idx + e;
            b = j / 4;
            if (e == 0 || b != lastb) begin
                ra = (64'(EdgeBase) + 64'(b) * 32) % AMod;
                exp_rd.push_back(ra[32:0]);
                nrd_exp++;
                lastb = b;
            end
            ed = edge_at(j);
            da = (64'(ed[31:0]) * 32) % AMod;
            exp_up.push_back({da[32:0], exp_val(prop, ed[63:32], ctl)});
        end
    endtask

    // HBM and consumer responders
    initial begin
        update_resp = 1'b0;
        end_rd      = 1'b0;
        read_data   = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                cstate      = 0;
                update_resp = 1'b0;
                end_rd      = 1'b0;
                hbm_pend    = 0;
                exp_up.delete();
                exp_rd.delete();
            end else begin
                if (mgu_resp) n_resp++;
                if (end_rd) begin
                    end_rd    = 1'b0;
                    read_data = {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom};
                end else if (hbm_pend) begin
                    if (hbm_wait == 0) begin
                        end_rd    = 1'b1;
                        read_data = beat_at(hbm_addr);
                        hbm_pend  = 0;
                    end else begin
                        hbm_wait--;
                    end
                end
                if (start_rd) begin
                    check("rd_single", {hbm_pend, end_rd}, 0);
                    if (n_rd == 0) first_rd = read_addr;
                    last_rd = read_addr;
                    n_rd++;
                    if (exp_rd.size() == 0) check("rd_unexp", start_rd, 0);
                    else check("read_addr", read_addr, exp_rd.pop_front());
                    hbm_pend = 1;
                    hbm_wait = $urandom_range(0, 4);
                    hbm_addr = read_addr;
                end
                case (cstate)
                    0: if (update_ready) begin
                        cap      = update;
                        last_upd = update;
                        stable   = 1;
                        n_upd++;
                        if (exp_up.size() == 0) check("upd_unexp", update_ready, 0);
                        else check("update", update, exp_up.pop_front());
                        cwait  = (hold_mode < 0) ? $urandom_range(0, 3) : hold_mode;
                        cstate = 1;
                    end
                    1: begin
                        if (!(update_ready === 1'b1 && update === cap)) stable = 0;
                        if (cwait == 0) begin
                            check("upd_stable", stable, 1);
                            update_resp = 1'b1;
                            cstate      = 2;
                        end else begin
                            cwait--;
                        end
                    end
                    2: begin
                        check("rdy_drop", update_ready, 0);
                        cstate = 3;
                    end
                    default: begin
                        update_resp = 1'b0;
                        cstate      = 0;
                    end
                endcase
            end
        end
    end

    task automatic start_rec(input logic [31:0] prop, input logic [31:0] idx,
                             input logic [31:0] deg, input logic [1:0] ctl,
                             input int hold);
        model(prop, idx, deg, ctl);
        hold_mode = hold;
        n_rd      = 0;
        n_upd     = 0;
        n_resp    = 0;
        @(negedge clk);
        mgu_data  = {1'($urandom), prop, idx, deg};
        control   = ctl;
        mgu_ready = 1'b1;
        for (int k = 0; k < 20 && !mgu_resp; k++) @(negedge clk);
        check("accept", mgu_resp, 1);
        // ready stays high one extra cycle to model producer lag
        @(negedge clk);
        mgu_ready = 1'b0;
        mgu_data  = 97'({$urandom, $urandom, $urandom, $urandom});
        control   = 2'($urandom);
        if (deg == 0) check("deg0_idle", busy, 0);
    endtask

    task automatic wait_done(input logic [31:0] deg);
        bit done;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = !busy && exp_up.size() == 0 && exp_rd.size() == 0 && cstate == 0;
        end
        check("done", done, 1);
        @(negedge clk);
        check("n_upd", n_upd, deg);
        check("n_rd", n_rd, nrd_exp);
        check("n_resp", n_resp, 1);
    endtask

    task automatic run(input logic [31:0] prop, input logic [31:0] idx,
                       input logic [31:0] deg, input logic [1:0] ctl, input int hold);
        start_rec(prop, idx, deg, ctl, hold);
        wait_done(deg);
    endtask

    initial begin
        resetn    = 1'b0;
        mgu_ready = 1'b0;
        mgu_data  = '0;
        control   = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_outs", {mgu_resp, start_rd, update_ready, busy, read_addr, update}, 0);
        resetn = 1'b1;

        run(32'd5, 32'd0, 32'd0, 2'b10, -1);

        edge_mem[4] = {32'd3, 32'd7};
        run(32'd10, 32'd4, 32'd1, 2'b10, -1);
        check("t2_addr", last_rd, 33'h1_0000_0020);
        check("t2_upd", last_upd, {33'h0E0, 32'd13});

        run(32'd0, 32'd2, 32'd6, 2'b10, -1);
        check("t3_rd0", first_rd, 33'h1_0000_0000);
        check("t3_rd1", last_rd, 33'h1_0000_0020);

        edge_mem[8] = {32'h20, 32'd1};
        run(32'hFFFF_FFF0, 32'd8, 32'd1, 2'b10, -1);
        check("t4_sat", last_upd[31:0], 32'hFFFF_FFFF);
        edge_mem[9] = {32'hDEAD_BEEF, 32'd2};
        run(32'd7, 32'd9, 32'd1, 2'b01, -1);
        check("t4_bfs", last_upd[31:0], 32'd8);
        run(32'd7, 32'd9, 32'd1, 2'b00, -1);
        check("t4_plain", last_upd[31:0], 32'd7);

        run(32'd100, 32'd12, 32'd3, 2'b10, 10);

        start_rec(32'd20, 32'd0, 32'd4, 2'b10, 20);
        for (int k = 0; k < 500 && n_upd < 2; k++) @(negedge clk);
        check("t6_reach", n_upd, 2);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_outs", {mgu_resp, start_rd, update_ready, busy, read_addr, update}, 0);
        @(negedge clk);
        resetn = 1'b1;
        n_upd  = 0;
        n_rd   = 0;
        repeat (8) @(negedge clk);
        check("t6_quiet", {n_upd, n_rd, busy}, 0);
        run(32'd3, 32'd5, 32'd5, 2'b01, -1);

        for (int r = 0; r < 40; r++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom) : $urandom;
            run(p, 32'($urandom_range(0, 100000)), 32'($urandom_range(0, 9)),
                2'($urandom_range(0, 3)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
